operand_fetch_stage: RTL and testbench

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/operand_fetch_stage.sv | 120 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads both sources, tracks pending writes in a busy scoreboard, registers operands for execute.
// Latency: 1 cycle from accept to out_valid; register file writes pass through combinationally.
// Backpressure: in_ready drops on a RAW/WAW hazard or a full, stalled output register. OPERAND_FETCH_WB_BYPASS_EN enables writeback bypass.
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_WIDTH-1:0]    in_ra_sel,
  input  logic [SEL_WIDTH-1:0]    in_rb_sel,
  input  logic [SEL_WIDTH-1:0]    in_rd_sel,
  input  logic                    in_uses_ra,
  input  logic                    in_uses_rb,
  input  logic                    in_writes_rd,
  output logic [2*SEL_WIDTH-1:0]  rf_read_sel,
  input  logic [2*DATA_WIDTH-1:0] rf_read_data,
  output logic [SEL_WIDTH-1:0]    rf_write_sel,
  output logic [DATA_WIDTH-1:0]   rf_write_data,
  output logic                    rf_write_en,
  input  logic                    wb_valid,
  input  logic [SEL_WIDTH-1:0]    wb_sel,
  input  logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_ra_data,
  output logic [DATA_WIDTH-1:0]   out_rb_data,
  output logic [SEL_WIDTH-1:0]    out_rd_sel,
  output logic                    out_writes_rd
);

  localparam int NREGS = 1 << SEL_WIDTH;

  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_nxt;
  logic                  ra_hit;
  logic                  rb_hit;
  logic                  rd_hit;
  logic                  hazard;
  logic                  accept;
  logic [DATA_WIDTH-1:0] ra_data;
  logic [DATA_WIDTH-1:0] rb_data;

  // Port 0 carries source A, port 1 source B.
  assign rf_read_sel   = {in_rb_sel, in_ra_sel};

  // Writeback goes straight to the register file, unregistered.
  assign rf_write_en   = wb_valid;
  assign rf_write_sel  = wb_sel;
  assign rf_write_data = wb_data;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  logic ra_wb;
  logic rb_wb;
  logic rd_wb;

  // A same-cycle writeback resolves the pending write, so it cancels the hazard and supplies the operand.
  assign ra_wb   = wb_valid && (wb_sel == in_ra_sel);
  assign rb_wb   = wb_valid && (wb_sel == in_rb_sel);
  assign rd_wb   = wb_valid && (wb_sel == in_rd_sel);
  assign ra_hit  = in_uses_ra   && busy[in_ra_sel] && !ra_wb;
  assign rb_hit  = in_uses_rb   && busy[in_rb_sel] && !rb_wb;
  assign rd_hit  = in_writes_rd && busy[in_rd_sel] && !rd_wb;
  assign ra_data = ra_wb ? wb_data : rf_read_data[DATA_WIDTH-1:0];
  assign rb_data = rb_wb ? wb_data : rf_read_data[2*DATA_WIDTH-1:DATA_WIDTH];
`else
  // Without bypass the hazard holds until the busy bit has actually cleared.
  assign ra_hit  = in_uses_ra   && busy[in_ra_sel];
  assign rb_hit  = in_uses_rb   && busy[in_rb_sel];
  assign rd_hit  = in_writes_rd && busy[in_rd_sel];
  assign ra_data = rf_read_data[DATA_WIDTH-1:0];
  assign rb_data = rf_read_data[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

  assign hazard   = ra_hit || rb_hit || rd_hit;
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Scoreboard next state: writeback clears first so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) begin
      busy_nxt[wb_sel] = 1'b0;
    end
    if (accept && in_writes_rd) begin
      busy_nxt[in_rd_sel] = 1'b1;
    end
  end

  // Scoreboard register; reset drops every pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Output register: loads on accept, empties on drain, otherwise holds stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_ra_data   <= '0;
      out_rb_data   <= '0;
      out_rd_sel    <= '0;
      out_writes_rd <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_ra_data   <= ra_data;
      out_rb_data   <= rb_data;
      out_rd_sel    <= in_rd_sel;
      out_writes_rd <= in_writes_rd;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a register file model and an output scoreboard.
// Expected operands are computed from driven selects, the model register contents and writeback inputs.
// Build with OPERAND_FETCH_WB_BYPASS_EN to match a bypass-enabled design.
module tb_operand_fetch_stage;

  localparam int DW = 32;
  localparam int SW = 4;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_ra_sel;
  logic [SW-1:0]   in_rb_sel;
  logic [SW-1:0]   in_rd_sel;
  logic            in_uses_ra;
  logic            in_uses_rb;
  logic            in_writes_rd;
  logic [2*SW-1:0] rf_read_sel;
  logic [2*DW-1:0] rf_read_data;
  logic [SW-1:0]   rf_write_sel;
  logic [DW-1:0]   rf_write_data;
  logic            rf_write_en;
  logic            wb_valid;
  logic [SW-1:0]   wb_sel;
  logic [DW-1:0]   wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_ra_data;
  logic [DW-1:0]   out_rb_data;
  logic [SW-1:0]   out_rd_sel;
  logic            out_writes_rd;

  always #5 clk = ~clk;

  operand_fetch_stage #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra_sel(in_ra_sel), .in_rb_sel(in_rb_sel), .in_rd_sel(in_rd_sel),
    .in_uses_ra(in_uses_ra), .in_uses_rb(in_uses_rb), .in_writes_rd(in_writes_rd),
    .rf_read_sel(rf_read_sel), .rf_read_data(rf_read_data),
    .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ra_data(out_ra_data), .out_rb_data(out_rb_data),
    .out_rd_sel(out_rd_sel), .out_writes_rd(out_writes_rd)
  );

  // Register file model: combinational read, written from the writeback inputs.
  logic [DW-1:0] regs [16];
  assign rf_read_data = {regs[rf_read_sel[2*SW-1:SW]], regs[rf_read_sel[SW-1:0]]};

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [SW-1:0] rd;
    logic          w;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   nfire      = 0;
  int   f0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drv(input logic v, input int ra, input int rb, input int rd,
                     input logic ua, input logic ub, input logic wr);
    in_valid     = v;
    in_ra_sel    = SW'(ra);
    in_rb_sel    = SW'(rb);
    in_rd_sel    = SW'(rd);
    in_uses_ra   = ua;
    in_uses_rb   = ub;
    in_writes_rd = wr;
  endtask

  // One clock: observe handshakes at the falling edge, return just after the rising edge.
  task automatic cyc();
    exp_t          e;
    exp_t          g;
    logic          wf;
    logic [SW-1:0] ws;
    logic [DW-1:0] wd;
    @(negedge clk);
    wf = wb_valid;
    ws = wb_sel;
    wd = wb_data;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        nfire++;
        chk("sb_has_entry", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sb_ra_data", out_ra_data, e.a);
          chk("sb_rb_data", out_rb_data, e.b);
          chk("sb_rd_sel", out_rd_sel, e.rd);
          chk("sb_writes_rd", out_writes_rd, e.w);
        end
      end
      if (in_valid && in_ready) begin
        g.a  = (BYP && wb_valid && wb_sel == in_ra_sel) ? wb_data : regs[in_ra_sel];
        g.b  = (BYP && wb_valid && wb_sel == in_rb_sel) ? wb_data : regs[in_rb_sel];
        g.rd = in_rd_sel;
        g.w  = in_writes_rd;
        q.push_back(g);
      end
    end
    @(posedge clk);
    #1;
    if (wf) regs[ws] = wd;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = DW'(i * 'h11);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_sel    = '0;
    wb_data   = '0;
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ra_data", out_ra_data, 0);
    chk("rst_rb_data", out_rb_data, 0);
    chk("rst_rd_sel", out_rd_sel, 0);
    chk("rst_writes_rd", out_writes_rd, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Basic fetch: ra=1, rb=2.
    out_ready = 1'b1;
    drv(1, 1, 2, 0, 1, 1, 0);
    #1;
    chk("rf_read_sel", rf_read_sel, 8'h21);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_ra", out_ra_data, 32'h11);
    chk("basic_rb", out_rb_data, 32'h22);
    cyc();
    chk("drain_clears_valid", out_valid, 0);

    // RAW on r3 resolved by writeback.
    drv(1, 0, 0, 3, 0, 0, 1);
    cyc();
    drv(1, 3, 0, 0, 1, 0, 0);
    #1;
    chk("raw_stall0", in_ready, 0);
    cyc();
    chk("raw_stall1", in_ready, 0);
    cyc();
    chk("raw_stall2", in_ready, 0);
    wb_valid = 1'b1;
    wb_sel   = 4'd3;
    wb_data  = 32'hABCD0003;
    #1;
    chk("wr_en_pass", rf_write_en, 1);
    chk("wr_sel_pass", rf_write_sel, 4'd3);
    chk("wr_data_pass", rf_write_data, 32'hABCD0003);
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    chk("raw_bypass_accept", in_ready, 1);
    cyc();
    wb_valid = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("raw_bypass_data", out_ra_data, 32'hABCD0003);
`else
    chk("raw_wb_cycle_stall", in_ready, 0);
    cyc();
    wb_valid = 1'b0;
    #1;
    chk("raw_accept_after_wb", in_ready, 1);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("raw_late_data", out_ra_data, 32'hABCD0003);
`endif
    cyc();

    // Output stall for four cycles, then drain and accept together.
    out_ready = 1'b0;
    drv(1, 4, 5, 6, 1, 1, 0);
    cyc();
    drv(1, 6, 7, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_ra", out_ra_data, 32'h44);
      chk("stall_rb", out_rb_data, 32'h55);
      chk("stall_rd", out_rd_sel, 4'd6);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", in_ready, 1);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("release_next_valid", out_valid, 1);
    chk("release_next_ra", out_ra_data, 32'h66);
    chk("release_next_rb", out_rb_data, 32'h77);
    cyc();

    // Same-cycle set and clear of busy[5]: set wins.
    drv(1, 0, 0, 5, 0, 0, 1);
    wb_valid = 1'b1;
    wb_sel   = 4'd5;
    wb_data  = 32'h5555;
    cyc();
    wb_valid = 1'b0;
    drv(1, 5, 0, 0, 1, 0, 0);
    #1;
    chk("set_wins_busy5", in_ready, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    wb_valid = 1'b1;
    wb_data  = 32'h5A5A;
    cyc();
    wb_valid = 1'b0;
    drv(1, 5, 0, 0, 1, 0, 0);
    #1;
    chk("busy5_cleared", in_ready, 1);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc();

    // Reset during a stall with busy[7] pending.
    out_ready = 1'b0;
    drv(1, 0, 0, 7, 0, 0, 1);
    cyc();
    drv(1, 7, 0, 0, 1, 0, 0);
    cyc();
    chk("pre_reset_stall", in_ready, 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_ready_r7", in_ready, 1);
    out_ready = 1'b1;
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc();

    // Sixteen back-to-back independent instructions.
    f0 = nfire;
    for (int i = 0; i < 16; i++) begin
      drv(1, i, 15 - i, i, 1, 1, 0);
      #1;
      chk("b2b_ready", in_ready, 1);
      if (i > 0) chk("b2b_no_bubble", out_valid, 1);
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("b2b_output_count", 64'(nfire - f0), 64'd16);
    chk("final_idle", out_valid, 0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
